// File: rtl/mips_inst_encoder.sv
// Mini-assembler: packs symbolic MIPS instructions into 32-bit words and writes them
// sequentially to instruction memory. Optional rotating-XOR checksum: ENCODER_CHECKSUM_EN.
module mips_inst_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_in_ready;
    logic              r_we;
    logic              r_err;
    logic              r_full;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_legal;
    logic              w_ack_done;
    logic [ADDR_W:0]   w_count_inc;
    logic [31:0]       w_word;

    // start wins over a simultaneous request; it is ignored while a write is in flight
    assign w_start_ok  = start && (r_state != S_WRITE);
    assign w_accept    = in_valid && r_in_ready && (r_state == S_IDLE) && !w_start_ok;
    assign w_legal     = (in_mnem <= 5'd22);
    assign w_ack_done  = (r_state == S_WRITE) && imem_ack;
    assign w_count_inc = r_count + 1'b1;

    // Field packing; fields a format does not use are left at zero
    always_comb begin
        w_word = 32'd0;
        case (in_mnem)
            5'd0:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
            5'd1:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
            5'd2:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
            5'd3:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
            5'd4:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100110};
            5'd5:  w_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000000};
            5'd6:  w_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000010};
            5'd7:  w_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000011};
            5'd8:  w_word = {6'b000000, in_rs, 15'd0, 6'b001000};
            5'd9:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b000100};
            5'd10: w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b000110};
            5'd11: w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b000111};
            5'd12: w_word = {6'b001000, in_rs, in_rt, in_imm};
            5'd13: w_word = {6'b001100, in_rs, in_rt, in_imm};
            5'd14: w_word = {6'b001101, in_rs, in_rt, in_imm};
            5'd15: w_word = {6'b001110, in_rs, in_rt, in_imm};
            5'd16: w_word = {6'b100011, in_rs, in_rt, in_imm};
            5'd17: w_word = {6'b101011, in_rs, in_rt, in_imm};
            5'd18: w_word = {6'b000100, in_rs, in_rt, in_imm};
            5'd19: w_word = {6'b000101, in_rs, in_rt, in_imm};
            5'd20: w_word = {6'b001111, 5'd0, in_rt, in_imm};
            5'd21: w_word = {6'b000010, in_target};
            5'd22: w_word = {6'b000011, in_target};
            default: w_word = 32'd0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal)
                    w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (imem_ack)
                    w_state_next = (w_count_inc == (ADDR_W+1)'(DEPTH)) ? S_FULL : S_IDLE;
            end
            S_FULL: begin
                if (w_start_ok)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_full     <= 1'b0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == S_IDLE);
            r_we       <= (w_state_next == S_WRITE);
            r_err      <= w_accept && !w_legal;
            r_full     <= (w_state_next == S_FULL);
            if (w_start_ok) begin
                r_ptr   <= base_addr;
                r_count <= '0;
            end else if (w_ack_done) begin
                r_ptr   <= r_ptr + 1'b1;
                r_count <= w_count_inc;
            end
            if (w_accept && w_legal) begin
                r_addr  <= r_ptr;
                r_wdata <= w_word;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = r_full;
    assign err        = r_err;

`ifdef ENCODER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clock) begin
        if (reset)
            r_checksum <= 32'd0;
        else if (w_start_ok)
            r_checksum <= 32'd0;
        else if (w_ack_done)
            r_checksum <= {r_checksum[30:0], r_checksum[31]} ^ r_wdata;
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: doc/mips_inst_encoder.md
Name: mips_inst_encoder

Overview:
- Hardware mini-assembler that loads instruction memory on the board for pipeline bring-up and self-test.
- Accepts one symbolic instruction per handshake: a mnemonic code plus register, shift, immediate and target fields.
- Packs each instruction into a 32-bit MIPS word using exactly the opcode/func encodings the pipeline control unit decodes.
- Writes the words sequentially into instruction memory through a write/ack interface.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory port.
- DEPTH, 256, number of words writable before the block reports full (≤ 2^ADDR_W).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: load base address, clear count/full/err; honoured only in IDLE or FULL.
- base_addr  in  ADDR_W  first word address, loaded on start.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_mnem  in  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 sllv, 10 srlv, 11 srav, 12 addi, 13 andi, 14 ori, 15 xori, 16 lw, 17 sw, 18 beq, 19 bne, 20 lui, 21 j, 22 jal; 23–31 illegal.
- in_rs, in_rt, in_rd, in_sa  in  5 each  register and shift-amount fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- imem_ack  in  1  memory has taken the write.
- count  out  ADDR_W+1  words written since the last start or reset.
- full  out  1  DEPTH words have been written.
- err  out  1  one-cycle pulse when an illegal mnemonic is rejected.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset values:
  - in_ready=0, then 1 on the first cycle after reset.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - count=0, full=0, err=0, checksum=0.
  - State IDLE, write pointer 0.
- Reset mid-write drops the pending word. The memory sees imem_we fall with no further access.
- States:
  - IDLE: in_ready=1.
  - WRITE: in_ready=0, imem_we=1.
  - FULL: in_ready=0.
- Accept happens when in_valid & in_ready at edge N:
  - Legal mnemonic: the encoded word and pointer are registered. imem_we=1 from cycle N+1. State → WRITE.
  - Illegal mnemonic (23–31): err=1 for cycle N+1. No write; pointer and count unchanged. State stays IDLE.
- WRITE:
  - imem_we, imem_addr and imem_wdata are held stable until imem_ack is sampled high.
  - On ack: imem_we=0 next cycle, pointer+1 (wraps modulo 2^ADDR_W), count+1.
  - If the new count equals DEPTH, go to FULL; otherwise go to IDLE.
  - Peak throughput is one word per 2 cycles (ack in the first WRITE cycle).
- FULL: full=1, requests are ignored; only start or reset leaves it.
- start in IDLE/FULL: pointer←base_addr, count←0, full←0. State → IDLE. The request-accept path is blocked in that cycle. start during WRITE is ignored.
- Encoding: fields are placed as op[31:26], rs[25:21], rt[20:16], rd[15:11], sa[10:6], func[5:0] / imm[15:0] / target[25:0]. Fields unused by a format are forced to 0 regardless of the inputs.
  - R-type, op 000000; funcs: add 100000, sub 100010, and 100100, or 100101, xor 100110.
  - sll/srl/sra: func 000000/000010/000011, rs=0.
  - sllv/srlv/srav: func 000100/000110/000111, sa=0.
  - jr: func 001000; only rs kept, rt=rd=sa=0.
  - I-type ops: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101.
  - lui: op 001111, rs=0.
  - J-type: j 000010, jal 000011.

Optional Feature:
- Macro: ENCODER_CHECKSUM_EN.
- Defined: checksum resets to 0. On each imem_ack in WRITE, checksum ← {checksum[30:0],checksum[31]} ^ imem_wdata. start clears it.
- Undefined: checksum is constant 0 and no checksum logic is generated.

Test Plan:
- start with base 0x10; add rs=1 rt=2 rd=3, ack in the same cycle → imem_addr 0x10, wdata 0x00221820, count 1, in_ready back to 1 two cycles after accept.
- lw rs=29 rt=8 imm=4 → 0x8FA80004; sll rt=5 rd=4 sa=2 with in_rs=9 → 0x00052080 (rs forced 0).
- lui rt=1 imm=0x1234 with in_rs=7 → 0x3C011234; jal target 0x10 → 0x0C000010.
- Ack delayed 3 cycles → we, addr and wdata stable for all 4 WRITE cycles; exactly one pointer increment.
- Mnemonic 25 → err pulse for one cycle, no imem_we, count unchanged; the next legal request goes to the same address.
- DEPTH=4, base 0xFE, ADDR_W=8: four writes land at 0xFE, 0xFF, 0x00, 0x01 → full=1, in_ready=0, fifth request ignored; start clears full, count=0, checksum=0.
